pressure_monitor: RTL and testbench

Sequential, parametrised blood-pressure health monitor for the health-check datapath. Accepts systolic/diastolic sample pairs and classifies each against programmable limits. Raises a latched alarm only after `PERSIST` consecutive abnormal samples, and holds it until an operator acknowledge arrives while pressure is normal. Sits between the sensor sampling front end and the system status/alarm aggregator, and exposes a per-sample `healthy_o` flag and event counters.

---
 rtl/pressure_pkg.sv | 25 ++
 rtl/pressure_classifier.sv | 33 +++
 rtl/pressure_monitor.sv | 131 +++++++++++++
 tb/tb_pressure_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pressure_pkg.sv
// Shared types and default limits for the blood-pressure monitor datapath.
package pressure_pkg;

    typedef enum logic [1:0] {
        ClsNormal  = 2'd0,
        ClsLow     = 2'd1,
        ClsHigh    = 2'd2,
        ClsInvalid = 2'd3
    } pclass_t;

    typedef enum logic [1:0] {
        StNormal  = 2'd0,
        StSuspect = 2'd1,
        StAlarm   = 2'd2
    } pstate_t;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefSysHi   = 140;
    localparam int unsigned DefSysLo   = 90;
    localparam int unsigned DefDiaHi   = 90;
    localparam int unsigned DefDiaLo   = 60;
    localparam int unsigned DefPersist = 3;
    localparam int unsigned DefCntW    = 8;

endpackage

// File: rtl/pressure_classifier.sv
// Combinational classifier for one systolic/diastolic pair against fixed limits.
module pressure_classifier
    import pressure_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned SYS_HI = DefSysHi,
    parameter int unsigned SYS_LO = DefSysLo,
    parameter int unsigned DIA_HI = DefDiaHi,
    parameter int unsigned DIA_LO = DefDiaLo
) (
    input  logic [WIDTH-1:0] sys_i,
    input  logic [WIDTH-1:0] dia_i,
    output pclass_t          class_o
);

    // Limits are deliberately truncated to the sample width.
    localparam logic [WIDTH-1:0] SysHi = WIDTH'(SYS_HI);
    localparam logic [WIDTH-1:0] SysLo = WIDTH'(SYS_LO);
    localparam logic [WIDTH-1:0] DiaHi = WIDTH'(DIA_HI);
    localparam logic [WIDTH-1:0] DiaLo = WIDTH'(DIA_LO);

    always_comb begin
        class_o = ClsNormal;
        if (sys_i <= dia_i) begin
            class_o = ClsInvalid;
        end else if ((sys_i > SysHi) || (dia_i > DiaHi)) begin
            class_o = ClsHigh;
        end else if ((sys_i < SysLo) || (dia_i < DiaLo)) begin
            class_o = ClsLow;
        end
    end

endmodule

// File: rtl/pressure_monitor.sv
// Blood-pressure monitor: classifies samples, tracks abnormal persistence and
// raises a latched alarm cleared by an acknowledge while pressure is normal.
module pressure_monitor
    import pressure_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned SYS_HI  = DefSysHi,
    parameter int unsigned SYS_LO  = DefSysLo,
    parameter int unsigned DIA_HI  = DefDiaHi,
    parameter int unsigned DIA_LO  = DefDiaLo,
    parameter int unsigned PERSIST = DefPersist,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] sys_i,
    input  logic [WIDTH-1:0] dia_i,
    input  logic             ack_i,
    output logic [1:0]       class_o,
    output logic             healthy_o,
    output logic             alarm_o,
    output logic [CNT_W-1:0] abn_cnt_o,
    output logic [CNT_W-1:0] alarm_cnt_o
);

    localparam logic [8:0] PersistW = 9'(PERSIST);

    pclass_t          cls;
    pclass_t          ref_cls;
    pclass_t          class_q;
    pstate_t          state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic             healthy_q;
    logic             alarm_q;
    logic [CNT_W-1:0] abn_cnt_q;
    logic [CNT_W-1:0] alarm_cnt_q;
    logic             abnormal;
    logic             enter_alarm;

    pressure_classifier #(
        .WIDTH  (WIDTH),
        .SYS_HI (SYS_HI),
        .SYS_LO (SYS_LO),
        .DIA_HI (DIA_HI),
        .DIA_LO (DIA_LO)
    ) u_classifier (
        .sys_i   (sys_i),
        .dia_i   (dia_i),
        .class_o (cls)
    );

    assign abnormal = in_valid_i && (cls != ClsNormal);
    // A same-cycle sample takes precedence over the registered class for ack.
    assign ref_cls  = in_valid_i ? cls : class_q;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        enter_alarm = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (abnormal) begin
                    if (PERSIST == 1) begin
                        state_d     = StAlarm;
                        enter_alarm = 1'b1;
                    end else begin
                        state_d = StSuspect;
                        run_d   = 8'd1;
                    end
                end
            end
            StSuspect: begin
                if (abnormal) begin
                    if (({1'b0, run_q} + 9'd1) == PersistW) begin
                        state_d     = StAlarm;
                        run_d       = 8'd0;
                        enter_alarm = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end else if (in_valid_i) begin
                    state_d = StNormal;
                    run_d   = 8'd0;
                end
            end
            StAlarm: begin
                if (ack_i && (ref_cls == ClsNormal)) begin
                    state_d = StNormal;
                end
            end
            default: begin
                state_d = StNormal;
                run_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StNormal;
            run_q       <= 8'd0;
            class_q     <= ClsNormal;
            healthy_q   <= 1'b1;
            alarm_q     <= 1'b0;
            abn_cnt_q   <= '0;
            alarm_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= (state_d == StAlarm);
            if (in_valid_i) begin
                class_q   <= cls;
                healthy_q <= (cls == ClsNormal);
            end
            if (abnormal && (abn_cnt_q != '1)) begin
                abn_cnt_q <= abn_cnt_q + 1'b1;
            end
            if (enter_alarm && (alarm_cnt_q != '1)) begin
                alarm_cnt_q <= alarm_cnt_q + 1'b1;
            end
        end
    end

    assign class_o     = class_q;
    assign healthy_o   = healthy_q;
    assign alarm_o     = alarm_q;
    assign abn_cnt_o   = abn_cnt_q;
    assign alarm_cnt_o = alarm_cnt_q;

endmodule

// File: tb/tb_pressure_monitor.sv
// Directed bench for pressure_monitor: default instance plus a PERSIST=1, CNT_W=2 instance.
module tb_pressure_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v1 = 1'b0, a1 = 1'b0;
    logic [7:0] s1 = '0, d1 = '0;
    logic [1:0] cls1;
    logic       hl1, al1;
    logic [7:0] abn1, acnt1;

    logic       v2 = 1'b0, a2 = 1'b0;
    logic [7:0] s2 = '0, d2 = '0;
    logic [1:0] cls2;
    logic       hl2, al2;
    logic [1:0] abn2, acnt2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pressure_monitor u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (v1),
        .sys_i       (s1),
        .dia_i       (d1),
        .ack_i       (a1),
        .class_o     (cls1),
        .healthy_o   (hl1),
        .alarm_o     (al1),
        .abn_cnt_o   (abn1),
        .alarm_cnt_o (acnt1)
    );

    pressure_monitor #(
        .PERSIST (1),
        .CNT_W   (2)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (v2),
        .sys_i       (s2),
        .dia_i       (d2),
        .ack_i       (a2),
        .class_o     (cls2),
        .healthy_o   (hl2),
        .alarm_o     (al2),
        .abn_cnt_o   (abn2),
        .alarm_cnt_o (acnt2)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock on instance 1; outputs are stable 1 time unit after the edge.
    task automatic cyc1(input logic v, input int s, input int d, input logic a);
        v1 = v; s1 = 8'(s); d1 = 8'(d); a1 = a;
        @(posedge clk);
        #1;
        v1 = 1'b0; a1 = 1'b0;
    endtask

    task automatic cyc2(input logic v, input int s, input int d, input logic a);
        v2 = v; s2 = 8'(s); d2 = 8'(d); a2 = a;
        @(posedge clk);
        #1;
        v2 = 1'b0; a2 = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        rst = 1'b0;
        check("rst_class", cls1, 0);
        check("rst_healthy", hl1, 1);
        check("rst_alarm", al1, 0);
        check("rst_abn", abn1, 0);
        check("rst_acnt", acnt1, 0);

        cyc1(1, 120, 80, 0);
        check("norm_class", cls1, 0);
        check("norm_healthy", hl1, 1);
        check("norm_alarm", al1, 0);
        check("norm_abn", abn1, 0);

        // Run broken by a normal sample
        cyc1(1, 150, 80, 0);
        check("hi_class", cls1, 2);
        check("hi_healthy", hl1, 0);
        cyc1(1, 150, 80, 0);
        cyc1(1, 120, 80, 0);
        check("brk_class", cls1, 0);
        cyc1(1, 150, 80, 0);
        check("brk_alarm", al1, 0);
        check("brk_abn", abn1, 3);

        // Run of three across a gap: 150/80, 150/80, 85/70
        cyc1(1, 150, 80, 0);
        check("run2_class", cls1, 2);
        check("run2_alarm", al1, 0);
        cyc1(1, 85, 70, 0);
        check("low_class", cls1, 1);
        check("alarm_rise", al1, 1);
        check("alarm_cnt1", acnt1, 1);
        cyc1(0, 0, 0, 0);
        cyc1(0, 0, 0, 0);
        check("idle_class", cls1, 1);
        cyc1(1, 100, 100, 0);
        check("inv_class", cls1, 3);
        check("inv_alarm", al1, 1);
        check("inv_abn", abn1, 6);
        check("inv_acnt", acnt1, 1);

        // Ack judged against registered abnormal class: ignored
        cyc1(0, 0, 0, 1);
        check("ack_reg_abn", al1, 1);
        // Ack with abnormal sample in same cycle: ignored
        cyc1(1, 150, 80, 1);
        check("ack_same_abn", al1, 1);
        check("ack_same_abn_cnt", abn1, 7);
        // Normal sample without ack: alarm held, ack not remembered
        cyc1(1, 120, 80, 0);
        check("alarm_hold_cls", cls1, 0);
        check("alarm_hold", al1, 1);
        cyc1(0, 0, 0, 0);
        check("alarm_hold2", al1, 1);
        // Ack alone against registered normal class clears
        cyc1(0, 0, 0, 1);
        check("ack_reg_norm", al1, 0);

        // Re-enter alarm, then ack with same-cycle normal sample
        cyc1(1, 150, 80, 0);
        cyc1(1, 150, 80, 0);
        check("re_pre", al1, 0);
        cyc1(1, 150, 80, 0);
        check("re_alarm", al1, 1);
        check("re_acnt", acnt1, 2);
        check("re_abn", abn1, 10);
        cyc1(1, 120, 80, 1);
        check("ack_same_norm", al1, 0);
        check("ack_same_cls", cls1, 0);
        // Back in NORMAL: a single abnormal sample does not alarm
        cyc1(1, 150, 80, 1);
        check("post_ack_alarm", al1, 0);
        check("post_ack_abn", abn1, 11);

        // PERSIST=1, CNT_W=2 instance
        cyc2(1, 50, 60, 0);
        check("p1_class", cls2, 3);
        check("p1_alarm", al2, 1);
        check("p1_abn", abn2, 1);
        check("p1_acnt", acnt2, 1);
        for (int i = 0; i < 4; i++) cyc2(1, 50, 60, 0);
        check("p1_abn_sat", abn2, 3);
        check("p1_acnt_hold", acnt2, 1);
        check("p1_alarm_hold", al2, 1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_alarm2", al2, 0);
        check("arst_abn2", abn2, 0);
        check("arst_acnt2", acnt2, 0);
        check("arst_class2", cls2, 0);
        check("arst_healthy2", hl2, 1);
        check("arst_abn1", abn1, 0);
        check("arst_acnt1", acnt1, 0);
        #8;
        rst = 1'b0;
        // No pending ack survives reset: fresh run still needs three samples
        cyc1(1, 150, 80, 0);
        cyc1(1, 150, 80, 0);
        check("post_rst_alarm", al1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
